// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one handshake memory port among NUM_MASTERS
// requestors. Each transaction is latched on grant, issued downstream until
// the memory raises busy (or an accept timeout expires), and completes with
// a one-cycle m_done (or m_err) pulse to the granted master.
module mem_port_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_read_req,
    input  logic [NUM_MASTERS-1:0]            m_write_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_write,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_read,
    output logic [NUM_MASTERS-1:0]            m_busy,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              memory_read_req,
    output logic                              memory_write_req,
    output logic [ADDR_WIDTH-1:0]             memory_addr,
    output logic [DATA_WIDTH-1:0]             memory_data_write,
    input  logic [DATA_WIDTH-1:0]             memory_data_read,
    input  logic                              memory_busy
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_last;
    logic [IDX_W-1:0] r_gnt;
    logic             r_op_wr;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_any;
    logic [IDX_W-1:0]       w_pick;

    // A master requests when either of its level request lines is high
    assign w_req = m_read_req | m_write_req;

    // Round-robin search: scan farthest-to-nearest so the nearest requester after r_rr_last wins
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int j = NUM_MASTERS; j >= 1; j--) begin
            if (w_req[(int'(r_rr_last) + j) % NUM_MASTERS]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'((int'(r_rr_last) + j) % NUM_MASTERS);
            end
        end
    end

    // Transaction FSM with all outputs registered; a write wins if both request lines are high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_rr_last         <= IDX_W'(NUM_MASTERS - 1);
            r_gnt             <= '0;
            r_op_wr           <= 1'b0;
            r_tmo_cnt         <= '0;
            m_data_read       <= '0;
            m_busy            <= '0;
            m_done            <= '0;
            m_err             <= '0;
            memory_read_req   <= 1'b0;
            memory_write_req  <= 1'b0;
            memory_addr       <= '0;
            memory_data_write <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt             <= w_pick;
                        r_rr_last         <= w_pick;
                        r_op_wr           <= m_write_req[w_pick];
                        memory_addr       <= m_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        memory_data_write <= m_data_write[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
                        memory_write_req  <= m_write_req[w_pick];
                        memory_read_req   <= ~m_write_req[w_pick];
                        m_busy            <= NUM_MASTERS'(1) << w_pick;
                        r_tmo_cnt         <= '0;
                        r_state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (memory_busy) begin
                        memory_read_req  <= 1'b0;
                        memory_write_req <= 1'b0;
                        r_state          <= S_WAIT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            memory_read_req  <= 1'b0;
                            memory_write_req <= 1'b0;
                            m_err            <= NUM_MASTERS'(1) << r_gnt;
                            r_state          <= S_ERR;
                        end
                    end
                end
                S_WAIT: begin
                    if (!memory_busy) begin
                        if (!r_op_wr) begin
                            m_data_read[int'(r_gnt)*DATA_WIDTH +: DATA_WIDTH] <= memory_data_read;
                        end
                        m_done  <= NUM_MASTERS'(1) << r_gnt;
                        r_state <= S_DONE;
                    end
                end
                S_DONE, S_ERR: begin
                    m_done  <= '0;
                    m_err   <= '0;
                    m_busy  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reactive memory model, transaction-level
// reference model compared every cycle, and directed scenarios with
// hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    rreq = '0;
    logic [N-1:0]    wreq = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_data_write = '0;
    logic [N*DW-1:0] m_data_read;
    logic [N-1:0]    m_busy, m_done, m_err;
    logic            memory_read_req, memory_write_req;
    logic [AW-1:0]   memory_addr;
    logic [DW-1:0]   memory_data_write;
    logic [DW-1:0]   memory_data_read = '0;
    logic            memory_busy = 1'b0;

    mem_port_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_read_req(rreq), .m_write_req(wreq),
        .m_addr(m_addr), .m_data_write(m_data_write), .m_data_read(m_data_read),
        .m_busy(m_busy), .m_done(m_done), .m_err(m_err),
        .memory_read_req(memory_read_req), .memory_write_req(memory_write_req),
        .memory_addr(memory_addr), .memory_data_write(memory_data_write),
        .memory_data_read(memory_data_read), .memory_busy(memory_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: busy rises hal_dly cycles after it sees a request, stays hal_hold cycles
    int          hal_dly   = 2;
    int          hal_hold  = 3;
    bit          hal_never = 1'b0;
    int          hal_t     = -1;
    logic [DW-1:0] hal_rdata = 32'hDEADBEEF;

    always @(posedge clk) begin
        #1;
        memory_data_read = hal_rdata;
        if (!reset) begin
            hal_t       = -1;
            memory_busy = 1'b0;
        end else if (hal_t < 0) begin
            if ((memory_read_req || memory_write_req) && !hal_never) begin
                hal_t       = 0;
                memory_busy = (hal_dly == 0);
            end
        end else begin
            hal_t++;
            if (hal_t >= hal_dly + hal_hold) begin
                hal_t       = -1;
                memory_busy = 1'b0;
            end else begin
                memory_busy = (hal_t >= hal_dly);
            end
        end
    end

    // Reference model: who owns the port, what phase its transaction is in, and results
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_DONE = 3, PH_ERR = 4;
    int            mdl_owner, mdl_phase, mdl_rr, mdl_cnt;
    bit            mdl_wr;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    logic [N*DW-1:0] mdl_rdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_owner = -1; mdl_phase = PH_IDLE; mdl_rr = N - 1; mdl_cnt = 0;
            mdl_wr = 1'b0; mdl_addr = '0; mdl_wdata = '0; mdl_rdata = '0;
        end else begin
            case (mdl_phase)
                PH_IDLE: begin
                    for (int j = 1; j <= N && mdl_owner < 0; j++) begin
                        int k;
                        k = (mdl_rr + j) % N;
                        if (rreq[k] || wreq[k]) begin
                            mdl_owner = k;
                            mdl_rr    = k;
                            mdl_wr    = wreq[k];
                            mdl_addr  = m_addr[k*AW +: AW];
                            mdl_wdata = m_data_write[k*DW +: DW];
                            mdl_cnt   = 0;
                            mdl_phase = PH_ISSUE;
                        end
                    end
                end
                PH_ISSUE: begin
                    if (memory_busy) mdl_phase = PH_WAIT;
                    else begin
                        mdl_cnt++;
                        if (mdl_cnt == TO) mdl_phase = PH_ERR;
                    end
                end
                PH_WAIT: begin
                    if (!memory_busy) begin
                        if (!mdl_wr) mdl_rdata[mdl_owner*DW +: DW] = memory_data_read;
                        mdl_phase = PH_DONE;
                    end
                end
                default: begin
                    mdl_owner = -1;
                    mdl_phase = PH_IDLE;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        logic [N-1:0] oh;
        oh = (mdl_owner >= 0) ? (N'(1) << mdl_owner) : '0;
        chk("m_busy", 128'(m_busy), 128'(oh));
        chk("m_done", 128'(m_done), 128'((mdl_phase == PH_DONE) ? oh : '0));
        chk("m_err", 128'(m_err), 128'((mdl_phase == PH_ERR) ? oh : '0));
        chk("mem_rd_req", 128'(memory_read_req), 128'(mdl_phase == PH_ISSUE && !mdl_wr));
        chk("mem_wr_req", 128'(memory_write_req), 128'(mdl_phase == PH_ISSUE && mdl_wr));
        chk("m_data_read", 128'(m_data_read), 128'(mdl_rdata));
        if (mdl_phase == PH_ISSUE) begin
            chk("mem_addr", 128'(memory_addr), 128'(mdl_addr));
            chk("mem_wdata", 128'(memory_data_write), 128'(mdl_wdata));
        end
    end

    // Stimulus bookkeeping
    bit            auto_clr = 1'b1;
    logic [N-1:0]  fin;
    int            glog[$];
    int            ndone, nerr, rd_cyc, wr_cyc, busy0_cyc;
    logic [AW-1:0] addr_seen;
    logic [DW-1:0] wdata_seen;

    task automatic clr_stats();
        glog.delete();
        ndone = 0; nerr = 0; rd_cyc = 0; wr_cyc = 0; busy0_cyc = 0;
        addr_seen = '0; wdata_seen = '0;
    endtask

    // One clock: observe at the falling edge, masters drop req after seeing done/err
    task automatic step();
        @(negedge clk);
        fin = m_done | m_err;
        for (int k = 0; k < N; k++) if (fin[k]) glog.push_back(k);
        ndone += $countones(m_done);
        nerr  += $countones(m_err);
        if (memory_read_req) begin rd_cyc++; addr_seen = memory_addr; end
        if (memory_write_req) begin
            wr_cyc++; addr_seen = memory_addr; wdata_seen = memory_data_write;
        end
        if (m_busy[0]) busy0_cyc++;
        @(posedge clk);
        #1;
        if (auto_clr) begin
            rreq = rreq & ~fin;
            wreq = wreq & ~fin;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run(2);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        clr_stats();
        run(3);
        chk("reset_outputs", 128'({m_busy, m_done, m_err, memory_read_req, memory_write_req,
                                   memory_addr, memory_data_write}), 128'(0));
        chk("reset_rdata", 128'(m_data_read), 128'(0));
        reset = 1'b1;
        run(2);

        // Single read by master 0
        clr_stats();
        m_addr[0*AW +: AW] = 26'h0000123;
        rreq[0] = 1'b1;
        run(15);
        chk("read_addr", 128'(addr_seen), 128'(26'h0000123));
        chk("read_done_cnt", 128'(ndone), 128'(1));
        chk("read_data", 128'(m_data_read[0*DW +: DW]), 128'(32'hDEADBEEF));
        chk("read_busy_cycles", 128'(busy0_cyc), 128'(7));

        // Write by master 1
        clr_stats();
        hal_rdata = 32'h12345678;
        m_addr[1*AW +: AW] = 26'h3FFFFFF;
        m_data_write[1*DW +: DW] = 32'hA5A5A5A5;
        wreq[1] = 1'b1;
        run(15);
        chk("write_req_seen", 128'(wr_cyc > 0), 128'(1));
        chk("write_data", 128'(wdata_seen), 128'(32'hA5A5A5A5));
        chk("write_addr", 128'(addr_seen), 128'(26'h3FFFFFF));
        chk("write_rdata_kept", 128'(m_data_read[1*DW +: DW]), 128'(0));
        chk("write_done_cnt", 128'(ndone), 128'(1));
        chk("write_done_master", 128'((glog.size() > 0) ? glog[0] : -1), 128'(1));

        // Read and write together on master 0: write wins
        clr_stats();
        m_data_write[0*DW +: DW] = 32'h0BADF00D;
        rreq[0] = 1'b1;
        wreq[0] = 1'b1;
        run(15);
        chk("both_no_read", 128'(rd_cyc), 128'(0));
        chk("both_write_seen", 128'(wr_cyc > 0), 128'(1));
        chk("both_rdata_kept", 128'(m_data_read[0*DW +: DW]), 128'(32'hDEADBEEF));

        // Round robin with continuous requests after reset
        auto_clr = 1'b0;
        hal_dly  = 0;
        hal_hold = 1;
        do_reset();
        clr_stats();
        rreq = 3'b111;
        run(26);
        rreq = 3'b000;
        run(8);
        chk("rr_count", 128'(glog.size() >= 6), 128'(1));
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk($sformatf("rr_grant%0d", i), 128'(glog[i]), 128'(i % 3));
        chk("rr_no_err", 128'(nerr), 128'(0));

        // Accept timeout: memory never answers
        auto_clr  = 1'b1;
        hal_never = 1'b1;
        do_reset();
        clr_stats();
        rreq = 3'b011;
        run(24);
        chk("tmo_err_cnt", 128'(nerr), 128'(2));
        chk("tmo_done_cnt", 128'(ndone), 128'(0));
        chk("tmo_req_cycles", 128'(rd_cyc), 128'(2 * TO));
        chk("tmo_first", 128'((glog.size() > 0) ? glog[0] : -1), 128'(0));
        chk("tmo_second", 128'((glog.size() > 1) ? glog[1] : -1), 128'(1));
        chk("tmo_rdata_kept", 128'(m_data_read), 128'(0));
        hal_never = 1'b0;
        run(3);

        // Asynchronous reset while waiting for busy to fall
        hal_dly  = 1;
        hal_hold = 6;
        clr_stats();
        rreq = 3'b001;
        run(4);
        chk("wait_busy", 128'(m_busy), 128'(3'b001));
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_outputs", 128'({m_busy, m_done, m_err, memory_read_req, memory_write_req,
                                       memory_addr, memory_data_write}), 128'(0));
        rreq = 3'b010;
        run(2);
        reset = 1'b1;
        run(20);
        chk("post_rst_master", 128'((glog.size() > 0) ? glog[0] : -1), 128'(1));
        chk("post_rst_done_cnt", 128'(ndone), 128'(1));
        chk("post_rst_err_cnt", 128'(nerr), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
